alu_serial_sequencer: RTL



---
 rtl/alu_serial_sequencer_pkg.sv | 57 +++++
 rtl/alu_serial_sequencer_if.sv | 50 +++++
 rtl/alu_serial_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_serial_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer_pkg
// Purpose : shared ALUControl codes, 1-bit slice Operation encodings, sequencer
//           state encodings and the ALUControl -> slice-control decoder.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package alu_serial_sequencer_pkg;

    localparam int unsigned CTRL_W     = 4;
    localparam int unsigned SLICE_OP_W = 2;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [SLICE_OP_W-1:0] {
        SLICE_AND  = 2'b00,
        SLICE_OR   = 2'b01,
        SLICE_ADD  = 2'b10,
        SLICE_LESS = 2'b11
    } slice_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic      legal;
        logic      is_slt;
        logic      ainvert;
        logic      binvert;
        slice_op_e op;
    } slice_ctrl_t;

    // Map an ALUControl code onto the slice drive pattern.
    function automatic slice_ctrl_t decode_ctrl(input logic [CTRL_W-1:0] ctrl);
        slice_ctrl_t c;
        c = '{legal: 1'b1, is_slt: 1'b0, ainvert: 1'b0, binvert: 1'b0, op: SLICE_AND};
        case (ctrl)
            ALU_AND: c.op = SLICE_AND;
            ALU_OR:  c.op = SLICE_OR;
            ALU_ADD: c.op = SLICE_ADD;
            ALU_SUB: begin c.binvert = 1'b1; c.op = SLICE_ADD; end
            // SLT reads the sign of a-b off the slice; Less is never used.
            ALU_SLT: begin c.binvert = 1'b1; c.op = SLICE_ADD; c.is_slt = 1'b1; end
            ALU_NOR: begin c.ainvert = 1'b1; c.binvert = 1'b1; c.op = SLICE_AND; end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer_if
// Purpose : bundles the request/response handshake and the 1-bit slice drive
//           between the control side, the sequencer and the ALU slice.
// Signals : start_valid/start_ready, ALUControl, a, b (request);
//           result, zero, illegal_op, done_valid/done_ready (response);
//           slice_a, slice_b, slice_Less, slice_Ainvert, slice_Binvert,
//           slice_CarryIn, slice_Operation -> slice; slice_Result,
//           slice_CarryOut <- slice.
// Modports: slave = sequencer side, master = environment side.
// -----------------------------------------------------------------------------
interface alu_serial_sequencer_if
    import alu_serial_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                  start_valid;
    logic                  start_ready;
    logic [CTRL_W-1:0]     ALUControl;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [WIDTH-1:0]      result;
    logic                  zero;
    logic                  illegal_op;
    logic                  done_valid;
    logic                  done_ready;
    logic                  slice_a;
    logic                  slice_b;
    logic                  slice_Less;
    logic                  slice_Ainvert;
    logic                  slice_Binvert;
    logic                  slice_CarryIn;
    logic [SLICE_OP_W-1:0] slice_Operation;
    logic                  slice_Result;
    logic                  slice_CarryOut;

    modport slave (
        input  start_valid, ALUControl, a, b, done_ready, slice_Result, slice_CarryOut,
        output start_ready, result, zero, illegal_op, done_valid,
               slice_a, slice_b, slice_Less, slice_Ainvert, slice_Binvert,
               slice_CarryIn, slice_Operation
    );

    modport master (
        output start_valid, ALUControl, a, b, done_ready, slice_Result, slice_CarryOut,
        input  start_ready, result, zero, illegal_op, done_valid,
               slice_a, slice_b, slice_Less, slice_Ainvert, slice_Binvert,
               slice_CarryIn, slice_Operation
    );
endinterface

// File: rtl/alu_serial_sequencer.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer
// Purpose : drives one external 1-bit ALU slice LSB-first, one bit per clock,
//           to compute a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR, holding the ripple
//           carry between cycles and returning the word over valid/ready.
// Ports   : clk, reset (synchronous, active-high);
//           bus (alu_serial_sequencer_if.slave): request, response, slice drive.
// Config  : SLT_OVERFLOW_FIX_EN - when defined, SLT corrects the sign bit of
//           a-b for signed overflow; otherwise SLT returns the raw sign bit.
// -----------------------------------------------------------------------------
module alu_serial_sequencer
    import alu_serial_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    alu_serial_sequencer_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_ainv;
    logic             r_binv;
    logic             r_is_slt;
    slice_op_e        r_op;
    logic             r_zero;
    logic             r_illegal;
    logic             r_done_valid;
    logic             r_start_ready;

    slice_ctrl_t      w_dec;
    logic             w_accept;
    logic             w_last;
    logic             w_set;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_final;

    assign w_dec        = decode_ctrl(bus.ALUControl);
    assign w_accept     = bus.start_valid && r_start_ready;
    assign w_last       = (r_idx == IDX_LAST);
    assign w_shift_next = {bus.slice_Result, r_shift[WIDTH-1:1]};

`ifdef SLT_OVERFLOW_FIX_EN
    // Overflow on the MSB is carry-in XOR carry-out; it flips the sign bit.
    assign w_set = bus.slice_Result ^ (r_carry ^ bus.slice_CarryOut);
`else
    assign w_set = bus.slice_Result;
`endif

    assign w_final = r_is_slt ? WIDTH'(w_set) : w_shift_next;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state and slice drive; slice is idle (all zero) outside RUN.
    always_comb begin
        w_state_next        = r_state;
        bus.slice_a         = 1'b0;
        bus.slice_b         = 1'b0;
        bus.slice_Less      = 1'b0;
        bus.slice_Ainvert   = 1'b0;
        bus.slice_Binvert   = 1'b0;
        bus.slice_CarryIn   = 1'b0;
        bus.slice_Operation = SLICE_OP_W'(SLICE_AND);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = w_dec.legal ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                bus.slice_a         = r_a[r_idx];
                bus.slice_b         = r_b[r_idx];
                bus.slice_Ainvert   = r_ainv;
                bus.slice_Binvert   = r_binv;
                bus.slice_CarryIn   = r_carry;
                bus.slice_Operation = SLICE_OP_W'(r_op);
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.done_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch, bit-serial datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_shift       <= '0;
            r_result      <= '0;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_ainv        <= 1'b0;
            r_binv        <= 1'b0;
            r_is_slt      <= 1'b0;
            r_op          <= SLICE_AND;
            r_zero        <= 1'b0;
            r_illegal     <= 1'b0;
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            r_start_ready <= (w_state_next == ST_IDLE);
            r_done_valid  <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_ainv   <= w_dec.ainvert;
                        r_binv   <= w_dec.binvert;
                        r_is_slt <= w_dec.is_slt;
                        r_op     <= w_dec.op;
                        r_idx    <= '0;
                        r_shift  <= '0;
                        // Subtraction's +1 enters as the LSB carry-in.
                        r_carry  <= w_dec.binvert;
                        if (!w_dec.legal) begin
                            r_result  <= '0;
                            r_zero    <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_shift <= w_shift_next;
                    r_carry <= bus.slice_CarryOut;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_result  <= w_final;
                        r_zero    <= (w_final == '0);
                        r_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.done_valid  = r_done_valid;
    assign bus.result      = r_result;
    assign bus.zero        = r_zero;
    assign bus.illegal_op  = r_illegal;

endmodule
